servo_sweep: RTL and testbench



---
 rtl/servo_sweep_pkg.sv | 20 ++
 rtl/servo_sweep_frame_timer.sv | 39 +++
 rtl/servo_sweep.sv | 142 ++++++++++++++
 tb/tb_servo_sweep.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/servo_sweep_pkg.sv
// Shared definitions for the servo sweep generator: FSM state encodings and the
// frame-length calculation that the pwm integration must also use.
package servo_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP_UP  = 3'd1,
        ST_DWELL_HI = 3'd2,
        ST_RAMP_DN  = 3'd3,
        ST_DWELL_LO = 3'd4
    } sweep_state_t;

    // 64-bit intermediate: 20000 us * 12 MHz overflows a 32-bit product.
    function automatic int period_ticks(input int clk_freq_hz, input int pwm_period_us);
        longint prod;
        prod = longint'(pwm_period_us) * longint'(clk_freq_hz);
        return int'(prod / 64'sd1000000);
    endfunction

endpackage

// File: rtl/servo_sweep_frame_timer.sv
// Free-running frame counter with a registered end-of-frame pulse; the pulse is
// high in the cycle the counter sits at its last value.
module frame_timer
    import servo_sweep_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 12000000,
    parameter int PWM_PERIOD_US = 20000
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);

    localparam int P_TICKS = period_ticks(CLK_FREQ_HZ, PWM_PERIOD_US);
    localparam int CW      = (P_TICKS > 1) ? $clog2(P_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(P_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        // Look ahead one count so the pulse lines up with the counter, not after it.
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/servo_sweep.sv
// Triangular duty sweep (min -> max -> min) for a servo pwm channel, updated once per frame.
// Optional macro SWEEP_HOLD_EN adds a 'hold' input that freezes the sweep.
module servo_sweep
    import servo_sweep_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 12000000,
    parameter int PWM_PERIOD_US = 20000,
    parameter int DUTY_RES_BITS = 8,
    parameter int DWELL_BITS    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
`ifdef SWEEP_HOLD_EN
    input  logic                     hold,
`endif
    input  logic [DUTY_RES_BITS-1:0] min_duty,
    input  logic [DUTY_RES_BITS-1:0] max_duty,
    input  logic [DUTY_RES_BITS-1:0] step,
    input  logic [DWELL_BITS-1:0]    dwell,
    output logic [DUTY_RES_BITS-1:0] duty,
    output logic                     enable,
    output logic                     busy,
    output logic                     frame_tick
);

    localparam int DW = DUTY_RES_BITS;

    sweep_state_t      state_q, state_d;
    logic [DW-1:0]     duty_q, duty_d;
    logic [DWELL_BITS-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DW-1:0]     lo_q, lo_d, hi_q, hi_d, stp_q, stp_d;
    logic [DWELL_BITS-1:0] dwell_q, dwell_d;
    logic              tick;
    logic              frozen;
    logic [DW:0]       up_sum, dn_lim;

    frame_timer #(
        .CLK_FREQ_HZ  (CLK_FREQ_HZ),
        .PWM_PERIOD_US(PWM_PERIOD_US)
    ) u_frame_timer (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(tick)
    );

`ifdef SWEEP_HOLD_EN
    assign frozen = hold;
`else
    assign frozen = 1'b0;
`endif

    // One extra bit so the limit tests can neither wrap nor underflow.
    assign up_sum = {1'b0, duty_q} + {1'b0, stp_q};
    assign dn_lim = {1'b0, lo_q} + {1'b0, stp_q};

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        dwell_cnt_d = dwell_cnt_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        stp_d       = stp_q;
        dwell_d     = dwell_q;

        if (stop && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        lo_d        = min_duty;
                        hi_d        = (max_duty > min_duty) ? max_duty : min_duty;
                        stp_d       = (step == '0) ? DW'(1) : step;
                        dwell_d     = dwell;
                        duty_d      = min_duty;
                        dwell_cnt_d = '0;
                        state_d     = ST_RAMP_UP;
                    end
                end
                ST_RAMP_UP: begin
                    if (tick && !frozen) begin
                        if (up_sum >= {1'b0, hi_q}) begin
                            duty_d  = hi_q;
                            state_d = (dwell_q == '0) ? ST_RAMP_DN : ST_DWELL_HI;
                        end else begin
                            duty_d = up_sum[DW-1:0];
                        end
                    end
                end
                ST_RAMP_DN: begin
                    if (tick && !frozen) begin
                        if ({1'b0, duty_q} <= dn_lim) begin
                            duty_d  = lo_q;
                            state_d = (dwell_q == '0) ? ST_RAMP_UP : ST_DWELL_LO;
                        end else begin
                            duty_d = duty_q - stp_q;
                        end
                    end
                end
                ST_DWELL_HI, ST_DWELL_LO: begin
                    if (tick && !frozen) begin
                        if (dwell_cnt_q == dwell_q - DWELL_BITS'(1)) begin
                            dwell_cnt_d = '0;
                            state_d     = (state_q == ST_DWELL_HI) ? ST_RAMP_DN : ST_RAMP_UP;
                        end else begin
                            dwell_cnt_d = dwell_cnt_q + DWELL_BITS'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            duty_q      <= '0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    // Sweep limits are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        lo_q    <= lo_d;
        hi_q    <= hi_d;
        stp_q   <= stp_d;
        dwell_q <= dwell_d;
    end

    assign duty       = duty_q;
    assign enable     = (state_q != ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign frame_tick = tick;

endmodule

// File: tb/tb_servo_sweep.sv
// Directed bench for servo_sweep with a 10-cycle frame; expected duty sequences are hand-derived.
module tb_servo_sweep;

    logic       clk = 1'b0;
    logic       rst, start, stop;
`ifdef SWEEP_HOLD_EN
    logic       hold;
`endif
    logic [7:0] min_duty, max_duty, step, dwell;
    logic [7:0] duty;
    logic       enable, busy, frame_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servo_sweep #(
        .CLK_FREQ_HZ  (1000000),
        .PWM_PERIOD_US(10),
        .DUTY_RES_BITS(8),
        .DWELL_BITS   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
`ifdef SWEEP_HOLD_EN
        .hold      (hold),
`endif
        .min_duty  (min_duty),
        .max_duty  (max_duty),
        .step      (step),
        .dwell     (dwell),
        .duty      (duty),
        .enable    (enable),
        .busy      (busy),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance past the next frame_tick so duty shows the new frame's value.
    task automatic next_frame();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 20) begin
            cycle(1);
            n++;
        end
        if (n >= 20) chk("frame_wait", int'(frame_tick), 1);
        cycle(1);
    endtask

    task automatic launch(input int mn, input int mx, input int st, input int dw);
        min_duty = 8'(mn);
        max_duty = 8'(mx);
        step     = 8'(st);
        dwell    = 8'(dw);
        start    = 1'b1;
        cycle(1);
        start    = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle(1);
        stop = 1'b0;
    endtask

    int seq_a [11] = '{20, 30, 40, 40, 40, 30, 20, 10, 10, 10, 20};
    int seq_b [4]  = '{255, 250, 255, 250};
    int seq_c [7]  = '{6, 7, 7, 6, 5, 5, 6};

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
`ifdef SWEEP_HOLD_EN
        hold = 1'b0;
`endif
        min_duty = '0; max_duty = '0; step = '0; dwell = '0;
        cycle(3);
        rst = 1'b0;

        chk("rst_duty", int'(duty), 0);
        chk("rst_enable", int'(enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tick", int'(frame_tick), 0);
        cycle(8);
        chk("tick_c8", int'(frame_tick), 0);
        cycle(1);
        chk("tick_c9", int'(frame_tick), 1);
        cycle(1);
        chk("tick_c10", int'(frame_tick), 0);
        cycle(9);
        chk("tick_c19", int'(frame_tick), 1);

        launch(10, 40, 10, 2);
        chk("a_entry_duty", int'(duty), 10);
        chk("a_entry_en", int'(enable), 1);
        chk("a_entry_busy", int'(busy), 1);
        foreach (seq_a[i]) begin
            next_frame();
            chk($sformatf("a_frame%0d", i), int'(duty), seq_a[i]);
            chk($sformatf("a_en%0d", i), int'(enable), 1);
        end

        // stop wins over a simultaneous start in RAMP_UP
        min_duty = 8'd99;
        stop = 1'b1; start = 1'b1;
        cycle(1);
        stop = 1'b0; start = 1'b0;
        chk("ss_busy", int'(busy), 0);
        chk("ss_enable", int'(enable), 0);
        chk("ss_duty", int'(duty), 20);
        next_frame();
        chk("ss_duty_held", int'(duty), 20);
        chk("ss_busy_held", int'(busy), 0);

        launch(250, 255, 10, 0);
        chk("b_entry_duty", int'(duty), 250);
        foreach (seq_b[i]) begin
            next_frame();
            chk($sformatf("b_frame%0d", i), int'(duty), seq_b[i]);
        end

        do_stop();
        launch(5, 7, 0, 1);
        chk("c_entry_duty", int'(duty), 5);
        foreach (seq_c[i]) begin
            next_frame();
            chk($sformatf("c_frame%0d", i), int'(duty), seq_c[i]);
            if (i == 1) begin
                min_duty = 8'd100; max_duty = 8'd200; step = 8'd9;
                start = 1'b1;
                cycle(1);
                start = 1'b0;
                chk("c_busy_start", int'(busy), 1);
            end
        end

        do_stop();
        launch(50, 20, 3, 0);
        chk("d_entry_duty", int'(duty), 50);
        for (int i = 0; i < 3; i++) begin
            next_frame();
            chk($sformatf("d_frame%0d", i), int'(duty), 50);
            chk($sformatf("d_busy%0d", i), int'(busy), 1);
        end

        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        chk("mrst_duty", int'(duty), 0);
        chk("mrst_enable", int'(enable), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_tick", int'(frame_tick), 0);

        stop = 1'b1; start = 1'b1;
        cycle(1);
        stop = 1'b0; start = 1'b0;
        chk("idle_stopstart_busy", int'(busy), 0);

`ifdef SWEEP_HOLD_EN
        launch(10, 40, 10, 0);
        next_frame(); chk("h_up20", int'(duty), 20);
        next_frame(); chk("h_up30", int'(duty), 30);
        next_frame(); chk("h_top", int'(duty), 40);
        next_frame(); chk("h_dn30", int'(duty), 30);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_frame();
            chk($sformatf("h_frozen%0d", i), int'(duty), 30);
            chk($sformatf("h_en%0d", i), int'(enable), 1);
        end
        hold = 1'b0;
        next_frame();
        chk("h_resume", int'(duty), 20);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
